// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU control path: opcodes, T-states
// and control-word bit positions.
package cpu_pkg;

   localparam int unsigned OP_W = 4;
   localparam int unsigned TS_W = 3;
   localparam int unsigned CW_W = 15;

   localparam logic [OP_W-1:0] OP_NOP = 4'd0;
   localparam logic [OP_W-1:0] OP_LDA = 4'd1;
   localparam logic [OP_W-1:0] OP_ADD = 4'd2;
   localparam logic [OP_W-1:0] OP_SUB = 4'd3;
   localparam logic [OP_W-1:0] OP_STA = 4'd4;
   localparam logic [OP_W-1:0] OP_LDI = 4'd5;
   localparam logic [OP_W-1:0] OP_JMP = 4'd6;
   localparam logic [OP_W-1:0] OP_JZ  = 4'd7;
   localparam logic [OP_W-1:0] OP_OUT = 4'd14;
   localparam logic [OP_W-1:0] OP_HLT = 4'd15;

   typedef enum logic [TS_W-1:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } tstate_e;

   // Bits 0-4 are the bus drivers; bit 14 requests the halt latch.
   localparam int unsigned CW_PC_OUT  = 0;
   localparam int unsigned CW_RAM_OUT = 1;
   localparam int unsigned CW_IR_OUT  = 2;
   localparam int unsigned CW_A_OUT   = 3;
   localparam int unsigned CW_ALU_OUT = 4;
   localparam int unsigned CW_PC_INC  = 5;
   localparam int unsigned CW_PC_LOAD = 6;
   localparam int unsigned CW_MAR_IN  = 7;
   localparam int unsigned CW_RAM_IN  = 8;
   localparam int unsigned CW_IR_IN   = 9;
   localparam int unsigned CW_A_IN    = 10;
   localparam int unsigned CW_B_IN    = 11;
   localparam int unsigned CW_OUT_IN  = 12;
   localparam int unsigned CW_ALU_SUB = 13;
   localparam int unsigned CW_HALT    = 14;

   typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode: (T-state, opcode, zero flag) -> control word and
// an end-of-instruction marker.
module ctrl_decode
   import cpu_pkg::*;
#(
   parameter int unsigned OPW = OP_W
) (
   input  tstate_e          tstate_i,
   input  logic [OPW-1:0]   opcode_i,
   input  logic             flag_z_i,
   output ctrl_word_t       cw_c_o,
   output logic             last_c_o
);

   always_comb begin
      cw_c_o   = '0;
      last_c_o = 1'b0;
      case (tstate_i)
         T0: begin
            cw_c_o[CW_PC_OUT] = 1'b1;
            cw_c_o[CW_MAR_IN] = 1'b1;
         end
         T1: begin
            cw_c_o[CW_RAM_OUT] = 1'b1;
            cw_c_o[CW_IR_IN]   = 1'b1;
            cw_c_o[CW_PC_INC]  = 1'b1;
         end
         T2: begin
            last_c_o = 1'b1;
            case (opcode_i)
               OPW'(OP_LDA), OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_STA): begin
                  cw_c_o[CW_IR_OUT] = 1'b1;
                  cw_c_o[CW_MAR_IN] = 1'b1;
                  last_c_o          = 1'b0;
               end
               OPW'(OP_LDI): begin
                  cw_c_o[CW_IR_OUT] = 1'b1;
                  cw_c_o[CW_A_IN]   = 1'b1;
               end
               OPW'(OP_JMP): begin
                  cw_c_o[CW_IR_OUT]  = 1'b1;
                  cw_c_o[CW_PC_LOAD] = 1'b1;
               end
               OPW'(OP_JZ): begin
                  cw_c_o[CW_IR_OUT]  = flag_z_i;
                  cw_c_o[CW_PC_LOAD] = flag_z_i;
               end
               OPW'(OP_OUT): begin
                  cw_c_o[CW_A_OUT]  = 1'b1;
                  cw_c_o[CW_OUT_IN] = 1'b1;
               end
               OPW'(OP_HLT): cw_c_o[CW_HALT] = 1'b1;
               OPW'(OP_NOP): ;
               default: ;
            endcase
         end
         T3: begin
            // Unexpected opcodes here terminate the instruction rather than hang.
            last_c_o = 1'b1;
            case (opcode_i)
               OPW'(OP_LDA): begin
                  cw_c_o[CW_RAM_OUT] = 1'b1;
                  cw_c_o[CW_A_IN]    = 1'b1;
               end
               OPW'(OP_ADD), OPW'(OP_SUB): begin
                  cw_c_o[CW_RAM_OUT] = 1'b1;
                  cw_c_o[CW_B_IN]    = 1'b1;
                  last_c_o           = 1'b0;
               end
               OPW'(OP_STA): begin
                  cw_c_o[CW_A_OUT]  = 1'b1;
                  cw_c_o[CW_RAM_IN] = 1'b1;
               end
               default: ;
            endcase
         end
         T4: begin
            last_c_o = 1'b1;
            if (opcode_i == OPW'(OP_ADD) || opcode_i == OPW'(OP_SUB)) begin
               cw_c_o[CW_ALU_OUT] = 1'b1;
               cw_c_o[CW_A_IN]    = 1'b1;
               cw_c_o[CW_ALU_SUB] = (opcode_i == OPW'(OP_SUB));
            end
         end
         default: last_c_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer: owns the T-state counter and halt latch, and gates the
// decoded control word with run/halt/reset.
module ctrl_seq
   import cpu_pkg::*;
#(
   parameter int unsigned OPW = OP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [OPW-1:0]   opcode,
   input  logic             flag_z,
   output logic             pc_out,
   output logic             ram_out,
   output logic             ir_out,
   output logic             a_out,
   output logic             alu_out,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             mar_in,
   output logic             ram_in,
   output logic             ir_in,
   output logic             a_in,
   output logic             b_in,
   output logic             out_in,
   output logic             alu_sub,
   output logic             halted,
   output logic [TS_W-1:0]  tstate
);

   tstate_e    tstate_q, tstate_d;
   logic       halted_q, halted_d;
   ctrl_word_t cw_dec;
   logic       last_dec;
   logic       active_c;

   ctrl_decode #(.OPW(OPW)) u_decode (
      .tstate_i (tstate_q),
      .opcode_i (opcode),
      .flag_z_i (flag_z),
      .cw_c_o   (cw_dec),
      .last_c_o (last_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tstate_q <= T0;
         halted_q <= 1'b0;
      end else begin
         tstate_q <= tstate_d;
         halted_q <= halted_d;
      end
   end

   // No edge is consumed unless the sequencer is actively running.
   always_comb begin
      tstate_d = tstate_q;
      halted_d = halted_q;
      active_c = rst_n & run & ~halted_q;
      if (active_c) begin
         if (last_dec) begin
            tstate_d = T0;
            halted_d = halted_q | cw_dec[CW_HALT];
         end else begin
            tstate_d = tstate_e'(TS_W'(tstate_q) + TS_W'(1));
         end
      end
   end

   assign pc_out  = active_c & cw_dec[CW_PC_OUT];
   assign ram_out = active_c & cw_dec[CW_RAM_OUT];
   assign ir_out  = active_c & cw_dec[CW_IR_OUT];
   assign a_out   = active_c & cw_dec[CW_A_OUT];
   assign alu_out = active_c & cw_dec[CW_ALU_OUT];
   assign pc_inc  = active_c & cw_dec[CW_PC_INC];
   assign pc_load = active_c & cw_dec[CW_PC_LOAD];
   assign mar_in  = active_c & cw_dec[CW_MAR_IN];
   assign ram_in  = active_c & cw_dec[CW_RAM_IN];
   assign ir_in   = active_c & cw_dec[CW_IR_IN];
   assign a_in    = active_c & cw_dec[CW_A_IN];
   assign b_in    = active_c & cw_dec[CW_B_IN];
   assign out_in  = active_c & cw_dec[CW_OUT_IN];
   assign alu_sub = active_c & cw_dec[CW_ALU_SUB];

   assign halted = halted_q;
   assign tstate = TS_W'(tstate_q);

endmodule
